memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM latch.
- Consumes the latched ALU result, store data and control; runs the data-memory handshake with the dcache (request held until `dhit`); stalls the pipe while an access is outstanding.
- Selects the writeback value (ALU / load / link) and registers it into the MEM/WB latch for the writeback stage.

Parameters:
- `WORD_W`, 32, data/address width.
- `REG_A_W`, 5, register-file destination index width.

Ports:
- `CLK` in 1: clock, all state on rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `mem_en` in 1: hazard-unit enable; MEM/WB latch may advance only when high.
- `flush` in 1: synchronous bubble insert into MEM/WB.
- `alu_out` in WORD_W: EX/MEM ALU result; also the memory address.
- `store_dat` in WORD_W: store data.
- `dren` in 1: load request.
- `dwen` in 1: store request.
- `reg_wen` in 1: register write enable.
- `wsel` in REG_A_W: destination register.
- `link_dat` in WORD_W: return address for link instructions.
- `wsrc` in 2: writeback source select.
- `halt` in 1: halt marker.
- `dhit` in 1: dcache access complete this cycle.
- `dmemload` in WORD_W: load data, valid when `dhit`.
- `dmemREN` out 1: dcache read request.
- `dmemWEN` out 1: dcache write request.
- `dmemaddr` out WORD_W: dcache address.
- `dmemstore` out WORD_W: dcache store data.
- `mem_stall` out 1: stage cannot complete this cycle.
- `wb_dat` out WORD_W: registered writeback data.
- `wb_sel` out REG_A_W: registered destination.
- `wb_wen` out 1: registered write enable.
- `wb_halt` out 1: registered, sticky halt.

Behaviour:
- Clock is `CLK`; reset is `nRST`, asynchronous, active-low.
- Reset value of every output and internal register is 0; FSM resets to IDLE.
- `dren` and `dwen` are never both high; if they are, the load wins and the store is ignored.
- `wsrc` encoding:
  - 00: `alu_out`.
  - 01: load data.
  - 10: `link_dat`.
  - 11: `alu_out`.
- FSM states and transitions:
  - IDLE:
    - Requests are driven combinationally from the inputs (`dmemREN`=`dren`, `dmemWEN`=`dwen` & !`dren`, `dmemaddr`=`alu_out`, `dmemstore`=`store_dat`).
    - Access with `dhit` in the same cycle completes with 0 wait.
    - Access without `dhit`: capture addr, data, type and control into the request register, then go to BUSY.
  - BUSY:
    - Requests driven from the request register; inputs are ignored.
    - On `dhit`: capture `dmemload`, then go to DONE if `mem_en`=0, else to IDLE.
  - DONE: data held, requests low; go to IDLE when `mem_en`=1.
  - DRAIN:
    - Entered from BUSY when `flush`=1.
    - Request stays asserted (the cache cannot abort); goes to IDLE on `dhit`.
    - Result is discarded.
- `mem_stall`:
  - High in IDLE when an access is present and `dhit`=0.
  - High in BUSY while `dhit`=0.
  - High in DRAIN regardless of `dhit`.
  - Low in DONE.
- MEM/WB latch update:
  - Loads when `mem_en`=1, `mem_stall`=0 and `flush`=0.
  - `flush` has priority: it clears `wb_dat`/`wb_sel`/`wb_wen` (bubble).
  - Otherwise the latch holds its value.
- `wb_halt`:
  - Sets when a halt-marked instruction is latched.
  - Stays set until reset; never cleared by flush.
- Halt instructions never issue memory requests, even if `dren`/`dwen` are set.
- Stores latch `wb_wen`=`reg_wen`; the bench expects 0 for stores.
- Latency: IDLE-path access with hit completes in 1 cycle; with N wait cycles it completes in N+1 cycles.
- `nRST` asserted mid-access:
  - Requests drop immediately (asynchronously).
  - FSM returns to IDLE.
  - Any outstanding cache transaction is the cache's responsibility.

Decomposition:
- `cpu_types_pkg` holds:
  - `word_t`.
  - `regbits_t`.
  - `wsrc_t` enum (WSRC_ALU, WSRC_LOAD, WSRC_LINK).
  - `mem_state_t` enum (IDLE, BUSY, DONE, DRAIN).
- One sub-module, `mem_wb_reg`: the enable/flush MEM/WB latch with sticky halt.
- FSM, request register and writeback mux stay in `memory_stage`.

Test Plan:
- Reset mid-BUSY (`alu_out`=0x40, `dren`=1, no hit), pulse `nRST` low → all outputs 0 immediately; FSM in IDLE after release.
- Load, `alu_out`=0x100, `wsrc`=01, `wsel`=8, `dhit` after 3 cycles with `dmemload`=0xDEADBEEF:
  - `mem_stall` high for 3 cycles.
  - `dmemaddr` stable at 0x100.
  - Next edge: `wb_dat`=0xDEADBEEF, `wb_sel`=8, `wb_wen`=1.
- Store, `alu_out`=0x200, `store_dat`=0x12345678, immediate `dhit`:
  - `dmemWEN`=1 for exactly that cycle.
  - No stall.
  - `wb_wen`=0 latched.
- Load hits while `mem_en`=0:
  - FSM enters DONE, `mem_stall`=0, `wb_*` unchanged.
  - Raise `mem_en` → loaded data appears in `wb_dat` at the next edge.
- `flush` during BUSY, load to 0x300:
  - Request remains asserted at 0x300 until `dhit`.
  - `mem_stall` high throughout.
  - `wb_wen`=0 after flush; FSM returns to IDLE.
- Link instruction (`wsrc`=10, `link_dat`=0x44, `wsel`=31) followed by `halt`=1:
  - `wb_dat`=0x44, `wb_sel`=31.
  - Then `wb_halt`=1, and it stays set through a subsequent `flush`.
  - No `dmemREN`/`dmemWEN` for the halt instruction.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the MEM stage: data/register widths, writeback source
// select encoding and the MEM-stage FSM states.
package cpu_types_pkg;
   localparam int DEF_WORD_W  = 32;
   localparam int DEF_REG_A_W = 5;

   typedef logic [DEF_WORD_W-1:0]  word_t;
   typedef logic [DEF_REG_A_W-1:0] regbits_t;

   // 2'b11 is unassigned and falls back to the ALU result
   typedef enum logic [1:0] {
      WSRC_ALU  = 2'b00,
      WSRC_LOAD = 2'b01,
      WSRC_LINK = 2'b10
   } wsrc_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BUSY  = 2'b01,
      DONE  = 2'b10,
      DRAIN = 2'b11
   } mem_state_t;
endpackage

// File: rtl/memory_stage_if.sv
// Data-cache port of the MEM stage. Request (dmemREN/dmemWEN with address and
// store data) is held stable by the master until the slave answers with dhit;
// dmemload is only meaningful in a cycle where dhit is high.
interface memory_stage_if #(
   parameter int WORD_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] dmemaddr;
   logic [WORD_W-1:0] dmemstore;
   logic              dhit;
   logic [WORD_W-1:0] dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline latch: advances on en, flush inserts a bubble, halt is
// sticky until reset and survives flushes.
module mem_wb_reg #(
   parameter int WORD_W  = 32,
   parameter int REG_A_W = 5
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               en,
   input  logic               flush,
   input  logic [WORD_W-1:0]  dat,
   input  logic [REG_A_W-1:0] sel,
   input  logic               wen,
   input  logic               halt,
   output logic [WORD_W-1:0]  wb_dat,
   output logic [REG_A_W-1:0] wb_sel,
   output logic               wb_wen,
   output logic               wb_halt
);
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_dat  <= '0;
         wb_sel  <= '0;
         wb_wen  <= 1'b0;
         wb_halt <= 1'b0;
      end else if (flush) begin
         wb_dat  <= '0;
         wb_sel  <= '0;
         wb_wen  <= 1'b0;
      end else if (en) begin
         wb_dat  <= dat;
         wb_sel  <= sel;
         wb_wen  <= wen;
         wb_halt <= wb_halt | halt;
      end
   end
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: dcache handshake FSM with request register, writeback
// source mux and the MEM/WB latch.
module memory_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W  = DEF_WORD_W,
   parameter int REG_A_W = DEF_REG_A_W
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               mem_en,
   input  logic               flush,
   input  logic [WORD_W-1:0]  alu_out,
   input  logic [WORD_W-1:0]  store_dat,
   input  logic               dren,
   input  logic               dwen,
   input  logic               reg_wen,
   input  logic [REG_A_W-1:0] wsel,
   input  logic [WORD_W-1:0]  link_dat,
   input  logic [1:0]         wsrc,
   input  logic               halt,
   memory_stage_if.master     dcif,
   output logic               mem_stall,
   output logic [WORD_W-1:0]  wb_dat,
   output logic [REG_A_W-1:0] wb_sel,
   output logic               wb_wen,
   output logic               wb_halt,
   output mem_state_t         state
);
   mem_state_t state_q, state_d;

   logic [WORD_W-1:0]  req_addr, req_store, req_link, load_q;
   logic [REG_A_W-1:0] req_sel;
   logic [1:0]         req_wsrc;
   logic               req_ren, req_wen, req_rwen;

   logic               acc_ren, acc_wen, access;
   logic               ren_c, wen_c, stall_c, cap_req, cap_load;
   logic [WORD_W-1:0]  addr_c, store_c;

   // Halt instructions never touch memory; load wins over store.
   assign acc_ren = dren & ~halt;
   assign acc_wen = dwen & ~dren & ~halt;
   assign access  = acc_ren | acc_wen;

   always_comb begin
      state_d  = state_q;
      ren_c    = 1'b0;
      wen_c    = 1'b0;
      addr_c   = alu_out;
      store_c  = store_dat;
      stall_c  = 1'b0;
      cap_req  = 1'b0;
      cap_load = 1'b0;
      case (state_q)
         IDLE: begin
            ren_c   = acc_ren;
            wen_c   = acc_wen;
            stall_c = access & ~dcif.dhit;
            if (access && !dcif.dhit) begin
               cap_req = 1'b1;
               state_d = BUSY;
            end else if (access && !mem_en && !flush) begin
               // zero-wait hit the latch cannot take yet: park it in DONE
               cap_req  = 1'b1;
               cap_load = 1'b1;
               state_d  = DONE;
            end
         end
         BUSY: begin
            ren_c   = req_ren;
            wen_c   = req_wen;
            addr_c  = req_addr;
            store_c = req_store;
            stall_c = ~dcif.dhit;
            if (dcif.dhit) begin
               cap_load = 1'b1;
               state_d  = (mem_en || flush) ? IDLE : DONE;
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            addr_c  = req_addr;
            store_c = req_store;
            if (mem_en || flush) state_d = IDLE;
         end
         default: begin
            // the cache cannot abort, so keep asking until it answers
            ren_c   = req_ren;
            wen_c   = req_wen;
            addr_c  = req_addr;
            store_c = req_store;
            stall_c = 1'b1;
            if (dcif.dhit) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         req_addr  <= '0;
         req_store <= '0;
         req_link  <= '0;
         req_sel   <= '0;
         req_wsrc  <= '0;
         req_ren   <= 1'b0;
         req_wen   <= 1'b0;
         req_rwen  <= 1'b0;
         load_q    <= '0;
      end else begin
         state_q <= state_d;
         if (cap_req) begin
            req_addr  <= alu_out;
            req_store <= store_dat;
            req_link  <= link_dat;
            req_sel   <= wsel;
            req_wsrc  <= wsrc;
            req_ren   <= acc_ren;
            req_wen   <= acc_wen;
            req_rwen  <= reg_wen;
         end
         if (cap_load) load_q <= dcif.dmemload;
      end
   end

   // Requests and stall are gated by reset so they drop without waiting for a clock.
   assign dcif.dmemREN   = nRST & ren_c;
   assign dcif.dmemWEN   = nRST & wen_c;
   assign dcif.dmemaddr  = nRST ? addr_c : '0;
   assign dcif.dmemstore = nRST ? store_c : '0;
   assign mem_stall      = nRST & stall_c;
   assign state          = state_q;

   logic               use_req;
   logic [1:0]         wsrc_m;
   logic [WORD_W-1:0]  wb_in_dat, load_m;
   logic [REG_A_W-1:0] sel_m;
   logic               rwen_m, halt_m;

   assign use_req = (state_q != IDLE);
   assign wsrc_m  = use_req ? req_wsrc : wsrc;
   assign sel_m   = use_req ? req_sel  : wsel;
   assign rwen_m  = use_req ? req_rwen : reg_wen;
   // a captured access can never be a halt, so only the IDLE path carries it
   assign halt_m  = ~use_req & halt;
   assign load_m  = (state_q == DONE) ? load_q : dcif.dmemload;

   always_comb begin
      case (wsrc_m)
         WSRC_LOAD: wb_in_dat = load_m;
         WSRC_LINK: wb_in_dat = use_req ? req_link : link_dat;
         default:   wb_in_dat = use_req ? req_addr : alu_out;
      endcase
   end

   mem_wb_reg #(
      .WORD_W  (WORD_W),
      .REG_A_W (REG_A_W)
   ) u_mem_wb_reg (
      .CLK     (CLK),
      .nRST    (nRST),
      .en      (mem_en & ~stall_c),
      .flush   (flush),
      .dat     (wb_in_dat),
      .sel     (sel_m),
      .wen     (rwen_m),
      .halt    (halt_m),
      .wb_dat  (wb_dat),
      .wb_sel  (wb_sel),
      .wb_wen  (wb_wen),
      .wb_halt (wb_halt)
   );
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random load/store/ALU/link
// traffic against a transaction-level model with a randomly stalling cache.
module tb_memory_stage;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        mem_en, flush, dren, dwen, reg_wen, halt;
   logic [31:0] alu_out, store_dat, link_dat;
   logic [4:0]  wsel;
   logic [1:0]  wsrc;
   logic        mem_stall, wb_wen, wb_halt;
   logic [31:0] wb_dat;
   logic [4:0]  wb_sel;
   mem_state_t  state;

   memory_stage_if #(.WORD_W(32)) dcif ();

   memory_stage #(.WORD_W(32), .REG_A_W(5)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .mem_en    (mem_en),
      .flush     (flush),
      .alu_out   (alu_out),
      .store_dat (store_dat),
      .dren      (dren),
      .dwen      (dwen),
      .reg_wen   (reg_wen),
      .wsel      (wsel),
      .link_dat  (link_dat),
      .wsrc      (wsrc),
      .halt      (halt),
      .dcif      (dcif),
      .mem_stall (mem_stall),
      .wb_dat    (wb_dat),
      .wb_sel    (wb_sel),
      .wb_wen    (wb_wen),
      .wb_halt   (wb_halt),
      .state     (state)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // scoreboard
   logic [31:0] exp_q[$];
   logic [31:0] last_dat;
   logic [4:0]  last_sel;
   logic        last_wen, exp_halt;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive_idle();
      mem_en = 1'b1; flush = 1'b0; dren = 1'b0; dwen = 1'b0; reg_wen = 1'b0;
      halt = 1'b0; alu_out = '0; store_dat = '0; link_dat = '0; wsel = '0; wsrc = '0;
      dcif.dhit = 1'b0; dcif.dmemload = '0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One instruction through MEM with mem_en high; the cache answers after
   // `waits` stall cycles. Expected writeback comes from the wsrc rule alone.
   task automatic run_instr(input logic dr, input logic dw, input logic [31:0] alu,
                            input logic [31:0] sd, input logic [31:0] lnk, input logic [1:0] ws,
                            input logic [4:0] sel, input logic rw, input int waits,
                            input logic [31:0] ld);
      logic        acc;
      logic [31:0] e;
      acc = dr | dw;
      if (ws == 2'b01)      e = ld;
      else if (ws == 2'b10) e = lnk;
      else                  e = alu;
      exp_q.push_back(e);
      alu_out = alu; store_dat = sd; link_dat = lnk; wsrc = ws; wsel = sel;
      reg_wen = rw; dren = dr; dwen = dw; halt = 1'b0; mem_en = 1'b1; flush = 1'b0;
      for (int c = 0; c <= waits; c++) begin
         if (c > 0) begin
            alu_out = $urandom; store_dat = $urandom; link_dat = $urandom;
            wsel = 5'($urandom); wsrc = 2'($urandom); reg_wen = 1'($urandom);
         end
         dcif.dhit     = acc && (c == waits);
         dcif.dmemload = (c == waits) ? ld : $urandom;
         @(negedge CLK);
         check("mem_stall", mem_stall, acc && (c < waits));
         check("dmemREN", dcif.dmemREN, dr);
         check("dmemWEN", dcif.dmemWEN, dw & ~dr);
         if (acc) check("dmemaddr", dcif.dmemaddr, alu);
         if (dw & ~dr) check("dmemstore", dcif.dmemstore, sd);
         step();
      end
      dcif.dhit = 1'b0; dren = 1'b0; dwen = 1'b0;
      last_dat = exp_q.pop_front();
      last_sel = sel;
      last_wen = rw;
      check("wb_dat", wb_dat, last_dat);
      check("wb_sel", wb_sel, last_sel);
      check("wb_wen", wb_wen, last_wen);
      check("wb_halt", wb_halt, exp_halt);
      check("state_idle", state, IDLE);
   endtask

   initial begin
      int k;
      exp_halt = 1'b0;
      drive_idle();
      nRST = 1'b1;
      #1 nRST = 1'b0;
      #2;
      check("rst_wb_dat", wb_dat, 0);
      check("rst_wb_sel", wb_sel, 0);
      check("rst_wb_wen", wb_wen, 0);
      check("rst_wb_halt", wb_halt, 0);
      check("rst_stall", mem_stall, 0);
      check("rst_state", state, IDLE);
      @(negedge CLK) nRST = 1'b1;
      step();

      // reset while a load is waiting
      alu_out = 32'h40; dren = 1'b1; wsrc = 2'b01; wsel = 5'd3; reg_wen = 1'b1;
      step();
      check("busy_state", state, BUSY);
      check("busy_ren", dcif.dmemREN, 1);
      #2 nRST = 1'b0;
      #1;
      check("arst_ren", dcif.dmemREN, 0);
      check("arst_addr", dcif.dmemaddr, 0);
      check("arst_stall", mem_stall, 0);
      check("arst_state", state, IDLE);
      check("arst_wb_dat", wb_dat, 0);
      dren = 1'b0;
      @(negedge CLK) nRST = 1'b1;
      step();
      check("post_rst_state", state, IDLE);

      // load with three wait cycles, then zero-wait store
      run_instr(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 2'b01, 5'd8, 1'b1, 3, 32'hDEADBEEF);
      run_instr(1'b0, 1'b1, 32'h200, 32'h12345678, 32'h0, 2'b00, 5'd4, 1'b0, 0, 32'h0);
      @(negedge CLK);
      check("store_wen_gone", dcif.dmemWEN, 0);
      step();
      check("nop_wb_wen", wb_wen, 0);

      // load completes while mem_en is low: result parks until enabled
      last_dat = wb_dat; last_sel = wb_sel; last_wen = wb_wen;
      alu_out = 32'h180; dren = 1'b1; wsrc = 2'b01; wsel = 5'd5; reg_wen = 1'b1; mem_en = 1'b0;
      @(negedge CLK);
      check("hold_stall_miss", mem_stall, 1);
      step();
      dcif.dhit = 1'b1; dcif.dmemload = 32'hCAFEF00D;
      @(negedge CLK);
      check("hold_stall_hit", mem_stall, 0);
      step();
      dcif.dhit = 1'b0; dcif.dmemload = $urandom;
      check("done_state", state, DONE);
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check("done_stall", mem_stall, 0);
         check("done_ren", dcif.dmemREN, 0);
         step();
         check("done_wb_dat", wb_dat, last_dat);
         check("done_wb_wen", wb_wen, last_wen);
      end
      mem_en = 1'b1;
      step();
      dren = 1'b0;
      check("done_rel_dat", wb_dat, 32'hCAFEF00D);
      check("done_rel_sel", wb_sel, 5);
      check("done_rel_wen", wb_wen, 1);
      check("done_rel_state", state, IDLE);

      // flush while a load is outstanding
      alu_out = 32'h300; dren = 1'b1; wsrc = 2'b01; wsel = 5'd9; reg_wen = 1'b1;
      step();
      flush = 1'b1; alu_out = $urandom; dren = 1'b0;
      @(negedge CLK);
      check("fl_ren", dcif.dmemREN, 1);
      check("fl_addr", dcif.dmemaddr, 32'h300);
      check("fl_stall", mem_stall, 1);
      step();
      flush = 1'b0;
      check("fl_wb_wen", wb_wen, 0);
      check("fl_state", state, DRAIN);
      @(negedge CLK);
      check("drain_ren", dcif.dmemREN, 1);
      check("drain_addr", dcif.dmemaddr, 32'h300);
      check("drain_stall", mem_stall, 1);
      step();
      dcif.dhit = 1'b1; dcif.dmemload = $urandom;
      @(negedge CLK);
      check("drain_hit_stall", mem_stall, 1);
      step();
      dcif.dhit = 1'b0;
      check("drain_done_state", state, IDLE);
      check("drain_wb_wen", wb_wen, 0);
      check("drain_wb_dat", wb_dat, 0);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 4);
         case (k)
            0: run_instr(1'b0, 1'b0, $urandom, $urandom, $urandom,
                         ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 5'($urandom), 1'($urandom), 0, 32'h0);
            1: run_instr(1'b1, 1'b0, $urandom, $urandom, $urandom, 2'b01, 5'($urandom), 1'b1,
                         $urandom_range(0, 4), $urandom);
            2: run_instr(1'b0, 1'b1, $urandom, $urandom, $urandom,
                         ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 5'($urandom), 1'b0,
                         $urandom_range(0, 4), 32'h0);
            3: run_instr(1'b0, 1'b0, $urandom, $urandom, $urandom, 2'b10, 5'($urandom), 1'b1, 0, 32'h0);
            default: run_instr(1'b1, 1'b1, $urandom, $urandom, $urandom, 2'b01, 5'($urandom), 1'b1,
                               $urandom_range(0, 3), $urandom);
         endcase
      end

      // link, then a halt that must not reach memory, then a flush
      run_instr(1'b0, 1'b0, $urandom, $urandom, 32'h44, 2'b10, 5'd31, 1'b1, 0, 32'h0);
      halt = 1'b1; dren = 1'b1; dwen = 1'b1; alu_out = $urandom; wsrc = 2'b00; reg_wen = 1'b0;
      @(negedge CLK);
      check("halt_ren", dcif.dmemREN, 0);
      check("halt_wen", dcif.dmemWEN, 0);
      check("halt_stall", mem_stall, 0);
      step();
      check("halt_set", wb_halt, 1);
      halt = 1'b0; dren = 1'b0; dwen = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      check("halt_after_flush", wb_halt, 1);
      check("halt_flush_wen", wb_wen, 0);
      exp_halt = 1'b1;
      run_instr(1'b0, 1'b0, 32'h55, $urandom, $urandom, 2'b00, 5'd2, 1'b1, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
